// File: rtl/seq_alu_top.sv
// Handshaked sequential ALU: single-cycle logic/compare/shift ops,
// iterative shift-add multiply and restoring divide.
module seq_alu_top #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALU_FUN,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] RESULT,
  output logic [WIDTH-1:0] RESULT_HI,
  output logic             CARRY,
  output logic             ZERO,
  output logic             DIV_BY_ZERO,
  output logic [1:0]       UNIT
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             is_div_q, is_div_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] rhi_q, rhi_d;
  logic             cy_q, cy_d;
  logic             z_q, z_d;
  logic             dbz_q, dbz_d;
  logic [1:0]       unit_q, unit_d;

  logic             accept;
  logic             is_long;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] sc_res, sc_rhi;
  logic             sc_cy, sc_dbz;
  logic [WIDTH:0]   madd;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   dsub;
  logic [WIDTH-1:0] it_hi, it_lo;

  assign IN_READY  = (state_q == IDLE) |
                     ((state_q == DONE) & OUT_READY);
  assign OUT_VALID = (state_q == DONE);
  assign accept    = IN_VALID & IN_READY;
  assign is_long   = (ALU_FUN == 4'h2) |
                     ((ALU_FUN == 4'h3) & (|B));
  assign sum       = {1'b0, A} + {1'b0, B};

  always_comb begin
    sc_res = '0;
    sc_rhi = '0;
    sc_cy  = 1'b0;
    sc_dbz = 1'b0;
    unique case (ALU_FUN)
      4'h0: {sc_cy, sc_res} = sum;
      4'h1: begin
        sc_res = A - B;
        sc_cy  = (A < B);
      end
      // reached here only for a zero divisor
      4'h3: begin
        sc_res = '1;
        sc_rhi = A;
        sc_dbz = 1'b1;
      end
      4'h4: sc_res = A & B;
      4'h5: sc_res = A | B;
      4'h6: sc_res = ~(A & B);
      4'h7: sc_res = ~(A | B);
      4'h9: sc_res = (A == B) ? WIDTH'(1) : '0;
      4'ha: sc_res = (A > B) ? WIDTH'(2) : '0;
      4'hb: sc_res = (A < B) ? WIDTH'(3) : '0;
      4'hc: sc_res = A >> 1;
      4'hd: sc_res = A << 1;
      4'he: sc_res = B >> 1;
      4'hf: sc_res = B << 1;
      default: ;
    endcase
  end

  assign madd   = lo_q[0] ? ({1'b0, hi_q} + {1'b0, opnd_q})
                          : {1'b0, hi_q};
  assign rem_sh = {hi_q, lo_q[WIDTH-1]};
  assign dsub   = rem_sh - {1'b0, opnd_q};

  // dsub[WIDTH] is the borrow: the shifted remainder is always
  // below twice the divisor, so the sign bit is exact
  always_comb begin
    if (is_div_q) begin
      it_hi = dsub[WIDTH] ? rem_sh[WIDTH-1:0] : dsub[WIDTH-1:0];
      it_lo = {lo_q[WIDTH-2:0], ~dsub[WIDTH]};
    end else begin
      it_hi = madd[WIDTH:1];
      it_lo = {madd[0], lo_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    res_d    = res_q;
    rhi_d    = rhi_q;
    cy_d     = cy_q;
    z_d      = z_q;
    dbz_d    = dbz_q;
    unit_d   = unit_q;
    unique case (state_q)
      EXEC: begin
        hi_d  = it_hi;
        lo_d  = it_lo;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          res_d   = it_lo;
          rhi_d   = it_hi;
          cy_d    = ~is_div_q & (|it_hi);
          z_d     = ~(|it_lo) & ~(|it_hi);
          dbz_d   = 1'b0;
        end
      end
      DONE: if (OUT_READY) state_d = IDLE;
      default: ;
    endcase
    if (accept) begin
      unit_d = ALU_FUN[3:2];
      if (is_long) begin
        state_d  = EXEC;
        cnt_d    = CW'(WIDTH);
        is_div_d = ALU_FUN[0];
        opnd_d   = ALU_FUN[0] ? B : A;
        lo_d     = ALU_FUN[0] ? A : B;
        hi_d     = '0;
      end else begin
        state_d = DONE;
        res_d   = sc_res;
        rhi_d   = sc_rhi;
        cy_d    = sc_cy;
        dbz_d   = sc_dbz;
        z_d     = ~(|sc_res) & ~(|sc_rhi);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      res_q    <= '0;
      rhi_q    <= '0;
      cy_q     <= 1'b0;
      z_q      <= 1'b0;
      dbz_q    <= 1'b0;
      unit_q   <= 2'b00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      res_q    <= res_d;
      rhi_q    <= rhi_d;
      cy_q     <= cy_d;
      z_q      <= z_d;
      dbz_q    <= dbz_d;
      unit_q   <= unit_d;
    end
  end

  assign RESULT      = res_q;
  assign RESULT_HI   = rhi_q;
  assign CARRY       = cy_q;
  assign ZERO        = z_q;
  assign DIV_BY_ZERO = dbz_q;
  assign UNIT        = unit_q;

endmodule

// File: tb/tb_seq_alu_top.sv
// Self-checking bench for seq_alu_top: directed cases plus
// randomized ops against an arithmetic reference model.
module tb_seq_alu_top;

  localparam int W = 16;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         IN_VALID = 1'b0;
  logic         IN_READY;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic [3:0]   ALU_FUN = '0;
  logic         OUT_VALID;
  logic         OUT_READY = 1'b1;
  logic [W-1:0] RESULT;
  logic [W-1:0] RESULT_HI;
  logic         CARRY;
  logic         ZERO;
  logic         DIV_BY_ZERO;
  logic [1:0]   UNIT;

  int n_chk = 0;
  int n_pass = 0;

  seq_alu_top #(.WIDTH(W)) dut (
    .CLK(CLK), .RST(RST),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .A(A), .B(B), .ALU_FUN(ALU_FUN),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .RESULT(RESULT), .RESULT_HI(RESULT_HI),
    .CARRY(CARRY), .ZERO(ZERO),
    .DIV_BY_ZERO(DIV_BY_ZERO), .UNIT(UNIT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         cy;
    logic         z;
    logic         dbz;
    logic [1:0]   unit;
    int           lat;
  } exp_t;

  function automatic exp_t model(input logic [W-1:0] a,
                                 input logic [W-1:0] b,
                                 input logic [3:0] f);
    exp_t e;
    longint ai = longint'(a);
    longint bi = longint'(b);
    longint m = 64'd1 << W;
    longint r = 0;
    longint h = 0;
    e.cy = 1'b0;
    e.dbz = 1'b0;
    e.lat = 1;
    case (f)
      4'h0: begin r = ai + bi; e.cy = (r >= m); r = r % m; end
      4'h1: begin r = (ai + m - bi) % m; e.cy = (ai < bi); end
      4'h2: begin
        r = (ai * bi) % m; h = (ai * bi) / m;
        e.cy = (h != 0); e.lat = W + 1;
      end
      4'h3: begin
        if (bi == 0) begin
          r = m - 1; h = ai; e.dbz = 1'b1;
        end else begin
          r = ai / bi; h = ai % bi; e.lat = W + 1;
        end
      end
      4'h4: r = longint'(a & b);
      4'h5: r = longint'(a | b);
      4'h6: r = longint'(~(a & b));
      4'h7: r = longint'(~(a | b));
      4'h8: r = 0;
      4'h9: r = (ai == bi) ? 1 : 0;
      4'ha: r = (ai > bi) ? 2 : 0;
      4'hb: r = (ai < bi) ? 3 : 0;
      4'hc: r = ai / 2;
      4'hd: r = (ai * 2) % m;
      4'he: r = bi / 2;
      default: r = (bi * 2) % m;
    endcase
    e.res = W'(r);
    e.hi = W'(h);
    e.z = (r == 0) && (h == 0);
    e.unit = f[3:2];
    return e;
  endfunction

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [3:0] f, input logic ordy,
                       output int lat, output bit rdy_seen);
    int k = 0;
    OUT_READY = ordy;
    A = a; B = b; ALU_FUN = f; IN_VALID = 1'b1;
    #1;
    while (!IN_READY && k < 50) begin
      @(posedge CLK); #1; k++;
    end
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    A = W'($urandom); B = W'($urandom); ALU_FUN = 4'($urandom);
    lat = 1;
    rdy_seen = 1'b0;
    while (!OUT_VALID && lat < 100) begin
      rdy_seen |= IN_READY;
      @(posedge CLK); #1; lat++;
    end
  endtask

  task automatic test_reset;
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    n_chk++;
    if ({IN_READY, OUT_VALID, RESULT, RESULT_HI, CARRY, ZERO,
         DIV_BY_ZERO, UNIT} !== {2'b10, 37'b0})
      $display("FAIL reset: rdy=%b vld=%b res=%h hi=%h c=%b z=%b d=%b u=%b, want rdy=1 rest 0",
               IN_READY, OUT_VALID, RESULT, RESULT_HI, CARRY, ZERO,
               DIV_BY_ZERO, UNIT);
    else n_pass++;
    RST = 1'b0;
  endtask

  task automatic test_add;
    logic [W-1:0] ta[2] = '{16'h0003, 16'hffff};
    logic [W-1:0] tb[2] = '{16'h000d, 16'h0001};
    logic [W-1:0] tr[2] = '{16'h0010, 16'h0000};
    logic [1:0]   tf[2] = '{2'b00, 2'b11};
    int lat;
    bit rs;
    for (int i = 0; i < 2; i++) begin
      issue(ta[i], tb[i], 4'h0, 1'b1, lat, rs);
      n_chk++;
      if ({RESULT, RESULT_HI, CARRY, ZERO, UNIT, lat} !==
          {tr[i], 16'h0, tf[i], 2'b00, 32'sd1})
        $display("FAIL add%0d: res=%h hi=%h c=%b z=%b u=%b lat=%0d, want res=%h c/z=%b lat=1",
                 i, RESULT, RESULT_HI, CARRY, ZERO, UNIT, lat, tr[i], tf[i]);
      else n_pass++;
    end
  endtask

  task automatic test_mul;
    int lat;
    bit rs;
    issue(16'h0100, 16'h0100, 4'h2, 1'b1, lat, rs);
    n_chk++;
    if ({RESULT, RESULT_HI, CARRY, ZERO, DIV_BY_ZERO, UNIT} !==
        {16'h0000, 16'h0001, 3'b100, 2'b00})
      $display("FAIL mul: res=%h hi=%h c=%b z=%b d=%b u=%b, want 0000/0001 c=1",
               RESULT, RESULT_HI, CARRY, ZERO, DIV_BY_ZERO, UNIT);
    else n_pass++;
    n_chk++;
    if (lat !== W + 1 || rs !== 1'b0)
      $display("FAIL mul_timing: lat=%0d ready_in_exec=%b, want lat=%0d ready=0",
               lat, rs, W + 1);
    else n_pass++;
  endtask

  task automatic test_div;
    int lat;
    bit rs;
    issue(16'h0006, 16'h0002, 4'h3, 1'b1, lat, rs);
    n_chk++;
    if ({RESULT, RESULT_HI, CARRY, DIV_BY_ZERO, lat} !==
        {16'h0003, 16'h0000, 2'b00, 32'sd17})
      $display("FAIL div: res=%h hi=%h c=%b d=%b lat=%0d, want 0003/0000 lat=17",
               RESULT, RESULT_HI, CARRY, DIV_BY_ZERO, lat);
    else n_pass++;
    issue(16'h0007, 16'h0000, 4'h3, 1'b1, lat, rs);
    n_chk++;
    if ({RESULT, RESULT_HI, CARRY, ZERO, DIV_BY_ZERO, lat} !==
        {16'hffff, 16'h0007, 3'b001, 32'sd1})
      $display("FAIL div0: res=%h hi=%h c=%b z=%b d=%b lat=%0d, want ffff/0007 d=1 lat=1",
               RESULT, RESULT_HI, CARRY, ZERO, DIV_BY_ZERO, lat);
    else n_pass++;
  endtask

  task automatic test_sweep;
    logic [W-1:0] ta[10] = '{16'h3, 16'h3, 16'h3, 16'h3, 16'h3,
                             16'h7, 16'h3, 16'h3, 16'h3, 16'h5};
    logic [W-1:0] tb[10] = '{16'hd, 16'hd, 16'hd, 16'hd, 16'h3,
                             16'h1, 16'h4, 16'hd, 16'h1, 16'h9};
    logic [3:0]   tf[10] = '{4'h4, 4'h5, 4'h6, 4'h7, 4'h9,
                             4'ha, 4'hb, 4'hd, 4'he, 4'h8};
    logic [W-1:0] tr[10] = '{16'h0001, 16'h000f, 16'hfffe, 16'hfff0,
                             16'h0001, 16'h0002, 16'h0003, 16'h0006,
                             16'h0000, 16'h0000};
    int lat;
    bit rs;
    for (int i = 0; i < 10; i++) begin
      issue(ta[i], tb[i], tf[i], 1'b1, lat, rs);
      n_chk++;
      if ({RESULT, RESULT_HI, CARRY, ZERO, UNIT, lat} !==
          {tr[i], 16'h0, 1'b0, tr[i] == 16'h0, tf[i][3:2], 32'sd1})
        $display("FAIL sweep op=%h: res=%h hi=%h c=%b z=%b u=%b lat=%0d, want res=%h",
                 tf[i], RESULT, RESULT_HI, CARRY, ZERO, UNIT, lat, tr[i]);
      else n_pass++;
    end
  endtask

  task automatic test_random;
    exp_t e;
    logic [W-1:0] a, b;
    logic [3:0] f;
    int lat;
    bit rs;
    for (int i = 0; i < 60; i++) begin
      a = W'($urandom);
      b = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3))
                                      : W'($urandom);
      f = 4'($urandom);
      e = model(a, b, f);
      issue(a, b, f, 1'b1, lat, rs);
      n_chk++;
      if ({RESULT, RESULT_HI, CARRY, ZERO, DIV_BY_ZERO, UNIT} !==
          {e.res, e.hi, e.cy, e.z, e.dbz, e.unit} || lat != e.lat)
        $display("FAIL rand op=%h a=%h b=%h: res=%h hi=%h c=%b z=%b d=%b u=%b lat=%0d, want %h %h %b %b %b %b %0d",
                 f, a, b, RESULT, RESULT_HI, CARRY, ZERO, DIV_BY_ZERO,
                 UNIT, lat, e.res, e.hi, e.cy, e.z, e.dbz, e.unit, e.lat);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure;
    exp_t e1, e2;
    int lat;
    bit rs;
    bit stable = 1'b1;
    IN_VALID = 1'b0;
    OUT_READY = 1'b1;
    @(posedge CLK); #1;
    e1 = model(16'h1234, 16'h0011, 4'h3);
    issue(16'h1234, 16'h0011, 4'h3, 1'b0, lat, rs);
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK); #1;
      if ({OUT_VALID, IN_READY, RESULT, RESULT_HI} !==
          {2'b10, e1.res, e1.hi}) stable = 1'b0;
    end
    n_chk++;
    if (!stable || lat != e1.lat)
      $display("FAIL bp_hold: vld=%b rdy=%b res=%h hi=%h lat=%0d, want 1 0 %h %h lat=%0d",
               OUT_VALID, IN_READY, RESULT, RESULT_HI, lat,
               e1.res, e1.hi, e1.lat);
    else n_pass++;
    e2 = model(16'h00f0, 16'h000f, 4'h5);
    A = 16'h00f0; B = 16'h000f; ALU_FUN = 4'h5;
    IN_VALID = 1'b1;
    OUT_READY = 1'b1;
    #1;
    n_chk++;
    if (IN_READY !== 1'b1)
      $display("FAIL bp_ready: IN_READY=%b, want 1", IN_READY);
    else n_pass++;
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    n_chk++;
    if ({OUT_VALID, RESULT, RESULT_HI} !== {1'b1, e2.res, e2.hi})
      $display("FAIL bp_next: vld=%b res=%h hi=%h, want 1 %h %h",
               OUT_VALID, RESULT, RESULT_HI, e2.res, e2.hi);
    else n_pass++;
    @(posedge CLK); #1;
    n_chk++;
    if (OUT_VALID !== 1'b0)
      $display("FAIL bp_dup: OUT_VALID=%b, want 0", OUT_VALID);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    exp_t e;
    logic [W-1:0] a, b;
    logic [3:0] f;
    int bad = 0;
    OUT_READY = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      f = 4'($urandom_range(4, 15));
      e = model(a, b, f);
      A = a; B = b; ALU_FUN = f; IN_VALID = 1'b1;
      @(posedge CLK); #1;
      if ({OUT_VALID, RESULT, RESULT_HI, UNIT} !==
          {1'b1, e.res, e.hi, e.unit}) bad++;
    end
    IN_VALID = 1'b0;
    n_chk++;
    if (bad != 0)
      $display("FAIL back_to_back: %0d of 8 cycles wrong, want 0", bad);
    else n_pass++;
    @(posedge CLK); #1;
  endtask

  task automatic test_reset_mid_div;
    exp_t e;
    int lat;
    bit rs;
    bit leak = 1'b0;
    OUT_READY = 1'b1;
    A = 16'hbeef; B = 16'h0003; ALU_FUN = 4'h3; IN_VALID = 1'b1;
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    n_chk++;
    if ({IN_READY, OUT_VALID, RESULT, RESULT_HI, CARRY, ZERO,
         DIV_BY_ZERO, UNIT} !== {2'b10, 37'b0})
      $display("FAIL rst_mid: rdy=%b vld=%b res=%h hi=%h c=%b z=%b d=%b u=%b, want rdy=1 rest 0",
               IN_READY, OUT_VALID, RESULT, RESULT_HI, CARRY, ZERO,
               DIV_BY_ZERO, UNIT);
    else n_pass++;
    repeat (20) begin
      @(posedge CLK); #1;
      leak |= OUT_VALID;
    end
    n_chk++;
    if (leak !== 1'b0)
      $display("FAIL rst_leak: OUT_VALID rose after abort, want 0");
    else n_pass++;
    A = 16'h0001; B = 16'h0002; ALU_FUN = 4'h0; IN_VALID = 1'b1;
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    IN_VALID = 1'b0;
    n_chk++;
    if (OUT_VALID !== 1'b0)
      $display("FAIL rst_wins: OUT_VALID=%b, want 0", OUT_VALID);
    else n_pass++;
    e = model(16'h8000, 16'h8001, 4'h0);
    issue(16'h8000, 16'h8001, 4'h0, 1'b1, lat, rs);
    n_chk++;
    if ({RESULT, CARRY, ZERO, lat} !== {e.res, e.cy, e.z, e.lat})
      $display("FAIL rst_after: res=%h c=%b z=%b lat=%0d, want %h %b %b %0d",
               RESULT, CARRY, ZERO, lat, e.res, e.cy, e.z, e.lat);
    else n_pass++;
  endtask

  initial begin
    test_reset;
    test_add;
    test_mul;
    test_div;
    test_sweep;
    test_random;
    test_backpressure;
    test_back_to_back;
    test_reset_mid_div;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/seq_alu_top.md
# seq_alu_top

Parametrised, handshaked successor to the 16-bit combinational ALU top. It accepts one operation per transaction on a valid/ready input port, runs single-cycle logic, compare and shift ops and multi-cycle iterative multiply/divide, then presents a registered result with flags on a valid/ready output port. It sits between the instruction sequencer and the register-file writeback, where back-pressure and variable latency must be tolerated.

## Interface

- WIDTH, 16: operand and result width, ≥4.
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  reset, synchronous, active-high.
- IN_VALID  in  1  operation request valid.
- IN_READY  out  1  block can accept an operation this cycle.
- A  in  WIDTH  operand A, unsigned.
- B  in  WIDTH  operand B, unsigned.
- ALU_FUN  in  4  opcode.
- OUT_VALID  out  1  result valid.
- OUT_READY  in  1  consumer accepts result.
- RESULT  out  WIDTH  primary result.
- RESULT_HI  out  WIDTH  multiply high half / divide remainder; 0 otherwise.
- CARRY  out  1  add carry-out, sub borrow, mul overflow (RESULT_HI≠0).
- ZERO  out  1  RESULT==0 and RESULT_HI==0.
- DIV_BY_ZERO  out  1  divide with B==0.
- UNIT  out  2  00 arith, 01 logic, 10 compare, 11 shift (ALU_FUN[3:2]).

## Operation

- Opcodes: 0000 A+B, 0001 A−B, 0010 A×B, 0011 A÷B, 0100 AND, 0101 OR, 0110 NAND, 0111 NOR, 1000 NOP (RESULT 0), 1001 EQ, 1010 GT, 1011 LT, 1100 A>>1, 1101 A<<1, 1110 B>>1, 1111 B<<1.
- Compare: RESULT = 1 (EQ), 2 (GT), 3 (LT) when true, else 0.
- Shifts logical, zero fill, by exactly 1.
- Add: {CARRY,RESULT} = A+B, WIDTH+1 bits. Sub: RESULT = A−B mod 2^WIDTH, CARRY = (A<B).
- Mul: shift-add, one bit of B per cycle, 2·WIDTH-bit product {RESULT_HI,RESULT}.
- Div: restoring, one quotient bit per cycle, RESULT = quotient, RESULT_HI = remainder.
- Div by zero: no iteration; RESULT = all ones, RESULT_HI = A, DIV_BY_ZERO=1, CARRY=0.
- CARRY, DIV_BY_ZERO are 0 for all ops where undefined above.
- A, B, ALU_FUN captured at accept (IN_VALID & IN_READY); later changes ignored.
- FSM states: IDLE, EXEC, DONE.
  - IDLE: accept → DONE for single-cycle ops and div-by-zero; → EXEC for mul/div, iteration counter loaded with WIDTH.
  - EXEC: one iteration per cycle; counter reaches 0 → DONE.
  - DONE: OUT_VALID=1, outputs stable; OUT_READY → IDLE, or directly accept a new op if IN_VALID same cycle (back-to-back).
- IN_READY = (state==IDLE) | (state==DONE & OUT_READY).

## Timing

- Reset: state IDLE, IN_READY=1, OUT_VALID=0, RESULT=0, RESULT_HI=0, CARRY=0, ZERO=0, DIV_BY_ZERO=0, UNIT=00, counter 0.
- RST in any state, including mid-EXEC, aborts the operation next edge; no partial result ever reaches OUT_VALID.
- RST wins over simultaneous accept.
- Single-cycle op accepted at edge N: OUT_VALID high after edge N+1.
- Mul/div (B≠0) accepted at edge N: OUT_VALID high after edge N+WIDTH+1.
- Throughput: single-cycle ops one per cycle with OUT_READY held high; mul/div one per WIDTH+1 cycles.
- OUT_VALID held with all result outputs unchanged until OUT_READY; OUT_VALID never drops without handshake.
- IN_READY low throughout EXEC and DONE while OUT_READY low.
- Outputs registered; no combinational path A/B/ALU_FUN → outputs. IN_READY depends combinationally on OUT_READY only.

## Test plan

- Reset then add A=0x0003 B=0x000D, OUT_READY=1 → RESULT 0x0010, CARRY 0, UNIT 00, OUT_VALID one cycle after accept; A=0xFFFF B=0x0001 → RESULT 0, CARRY 1, ZERO 1.
- Mul A=0x0100 B=0x0100 → RESULT 0x0000, RESULT_HI 0x0001, CARRY 1, OUT_VALID exactly 17 cycles after accept (WIDTH=16); IN_READY low during EXEC.
- Div A=0x0006 B=0x0002 → RESULT 0x0003, RESULT_HI 0; A=0x0007 B=0x0000 → RESULT 0xFFFF, RESULT_HI 0x0007, DIV_BY_ZERO 1, latency 1.
- Logic/compare/shift sweep A=0x0003 B=0x000D: AND 0x0001, OR 0x000F, NAND 0xFFFE, NOR 0xFFF0; EQ 3/3 → 1; GT 7/1 → 2; LT 3/4 → 3; A<<1 → 0x0006, B>>1 (B=1) → 0.
- Back-pressure: OUT_READY low 5 cycles after result → OUT_VALID and RESULT stable, IN_READY low; raise OUT_READY with IN_VALID high → new op accepted same cycle, no result lost or duplicated.
- Assert RST 5 cycles into a divide → next cycle IDLE, IN_READY 1, OUT_VALID 0, all outputs 0; following add completes normally.
